mult_div_unit: RTL and testbench

//  Iterative multiply/divide engine feeding the HI/LO registers of the multicycle CPU; parametrised successor of the fixed 32-bit Div/Mult block.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_cond_neg.sv | 12 +
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 tb/tb_mult_div_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding and controller state encoding.
package mdu_pkg;

  typedef enum logic {
    MDU_MULT = 1'b0,
    MDU_DIV  = 1'b1
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FIX,
    DONE,
    DZ
  } mdu_state_e;

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational two's-complement negate-if: y = neg ? -x : x.
module mdu_cond_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide feeding HI/LO.
// One iteration per cycle over a shared 2*WIDTH shift register.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q;
  logic               sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [CNT_W-1:0]   counter;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH:0]     rem_shift, add_a, add_b;
  logic [WIDTH+1:0]   add_res;
  logic               sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign sign_a = is_signed & a[WIDTH-1];
  assign sign_b = is_signed & b[WIDTH-1];

  mdu_cond_neg #(.W(WIDTH)) u_abs_a (.neg(sign_a), .x(a), .y(abs_a));
  mdu_cond_neg #(.W(WIDTH)) u_abs_b (.neg(sign_b), .x(b), .y(abs_b));

  // Shared adder: MULT adds the multiplicand into P, DIV trial-subtracts the
  // divisor from the shifted remainder; bit WIDTH+1 is the DIV borrow.
  assign acc_hi    = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo    = acc_q[WIDTH-1:0];
  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign sub       = (op_q == MDU_DIV);
  assign add_a     = sub ? rem_shift : {1'b0, acc_hi};
  assign add_b     = sub ? {1'b0, m_q} : {1'b0, {WIDTH{acc_lo[0]}} & m_q};
  assign add_res   = {1'b0, add_a} + ({1'b0, add_b} ^ {(WIDTH+2){sub}})
                   + {{(WIDTH+1){1'b0}}, sub};

  always_comb begin
    if (sub) begin
      if (!add_res[WIDTH+1]) acc_next = {add_res[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
      else                   acc_next = {rem_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {add_res[WIDTH:0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction: remainder follows the dividend's sign.
  mdu_cond_neg #(.W(2*WIDTH)) u_prod_fix (.neg(sign_a_q ^ sign_b_q), .x(acc_q),  .y(prod_fix));
  mdu_cond_neg #(.W(WIDTH))   u_quo_fix  (.neg(sign_a_q ^ sign_b_q), .x(acc_lo), .y(quo_fix));
  mdu_cond_neg #(.W(WIDTH))   u_rem_fix  (.neg(sign_a_q),            .x(acc_hi), .y(rem_fix));

  assign fix_hi = sub ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo = sub ? quo_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    div0    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = (op == MDU_DIV && b == '0) ? DZ : RUN;
      RUN: begin
        busy = 1'b1;
        if (counter == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        done    = 1'b1;
        div0    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= MDU_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      counter  <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          op_q     <= mdu_op_e'(op);
          sign_a_q <= sign_a;
          sign_b_q <= sign_b;
          counter  <= CNT_W'(WIDTH);
          if (op == MDU_DIV) begin
            m_q   <= abs_b;
            acc_q <= {{WIDTH{1'b0}}, abs_a};
          end else begin
            m_q   <= abs_a;
            acc_q <= {{WIDTH{1'b0}}, abs_b};
          end
        end
        RUN: begin
          acc_q   <= acc_next;
          counter <= counter - CNT_W'(1);
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, op32, sgn32, busy32, done32, div032;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, op8, sgn8, busy8, done8, div08;
  logic [7:0]  a8, b8, hi8, lo8;

  int          total = 0;
  int          bad   = 0;
  int          cycles;
  int          pulses;
  logic [63:0] got_hi, got_lo;
  logic        got_busy, got_div0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .is_signed(sgn32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .div0(div032),
    .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .div0(div08),
    .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one operation, scrambles operands after the start edge, and waits
  // (bounded) for done; cycles counts negedges after the start edge.
  task automatic run_op(input bit w8, input logic opv, input logic sgn,
                        input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; op8 = opv; sgn8 = sgn; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start32 = 1'b1; op32 = opv; sgn32 = sgn; a32 = av; b32 = bv;
    end
    cycles = 0;
    do begin
      @(negedge clk);
      start8  = 1'b0;
      start32 = 1'b0;
      a32     = $urandom;
      b32     = $urandom;
      a8      = 8'($urandom);
      b8      = 8'($urandom);
      cycles++;
    end while (!(w8 ? done8 : done32) && cycles < 200);
    got_hi   = w8 ? {56'b0, hi8} : {32'b0, hi32};
    got_lo   = w8 ? {56'b0, lo8} : {32'b0, lo32};
    got_busy = w8 ? busy8 : busy32;
    got_div0 = w8 ? div08 : div032;
  endtask

  initial begin
    reset = 1'b0;
    start32 = 1'b0; op32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    check("rst_hi32",   hi32,   32'h0);
    check("rst_lo32",   lo32,   32'h0);
    check("rst_busy32", busy32, 1'b0);
    check("rst_done32", done32, 1'b0);
    check("rst_div032", div032, 1'b0);
    check("rst_hi8",    hi8,    8'h0);

    run_op(0, MDU_MULT, 1'b0, 32'd7, 32'd6);
    check("mulu_lat",  cycles,   34);
    check("mulu_hi",   got_hi,   64'h0);
    check("mulu_lo",   got_lo,   64'd42);
    check("mulu_busy", got_busy, 1'b0);
    check("mulu_div0", got_div0, 1'b0);
    @(negedge clk);
    check("done_pulse", done32, 1'b0);

    run_op(0, MDU_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5);
    check("muls_hi", got_hi, 64'hFFFF_FFFF);
    check("muls_lo", got_lo, 64'hFFFF_FFF1);
    run_op(0, MDU_MULT, 1'b0, 32'hFFFF_FFFD, 32'd5);
    check("mulu2_hi", got_hi, 64'h4);
    check("mulu2_lo", got_lo, 64'hFFFF_FFF1);

    run_op(0, MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("divs_lat", cycles, 34);
    check("divs_lo",  got_lo, 64'hFFFF_FFFD);
    check("divs_hi",  got_hi, 64'hFFFF_FFFF);
    run_op(0, MDU_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE);
    check("divs2_lo", got_lo, 64'hFFFF_FFFD);
    check("divs2_hi", got_hi, 64'h1);
    run_op(0, MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divmin_lo",   got_lo,   64'h8000_0000);
    check("divmin_hi",   got_hi,   64'h0);
    check("divmin_div0", got_div0, 1'b0);
    run_op(0, MDU_DIV, 1'b0, 32'd5, 32'd9);
    check("divu_small_lo", got_lo, 64'h0);
    check("divu_small_hi", got_hi, 64'd5);
    run_op(0, MDU_DIV, 1'b0, 32'd100, 32'd7);
    check("divu_lo", got_lo, 64'd14);
    check("divu_hi", got_hi, 64'd2);

    run_op(0, MDU_DIV, 1'b1, 32'd55, 32'd0);
    check("dz_lat",  cycles,   1);
    check("dz_div0", got_div0, 1'b1);
    check("dz_busy", got_busy, 1'b0);
    check("dz_hi",   got_hi,   64'd2);
    check("dz_lo",   got_lo,   64'd14);
    @(negedge clk);
    check("dz_done_pulse", done32, 1'b0);
    check("dz_div0_pulse", div032, 1'b0);

    // start held high through RUN, FIX and the DONE cycle.
    @(negedge clk);
    start32 = 1'b1; op32 = MDU_MULT; sgn32 = 1'b0; a32 = 32'd7; b32 = 32'd6;
    @(negedge clk);
    a32 = 32'd9; b32 = 32'd9; op32 = MDU_DIV;
    cycles = 1;
    while (!done32 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("busy_start_lat", cycles, 34);
    check("busy_start_lo",  lo32,   32'd42);
    check("busy_start_hi",  hi32,   32'd0);
    @(negedge clk);
    check("done_start_busy", busy32, 1'b0);
    check("done_start_done", done32, 1'b0);
    start32 = 1'b0;

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    start32 = 1'b1; op32 = MDU_MULT; a32 = 32'd7; b32 = 32'd6;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy32, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_hi",   hi32,   32'h0);
    check("mid_rst_lo",   lo32,   32'h0);
    check("mid_rst_busy", busy32, 1'b0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) pulses++;
    end
    check("mid_rst_nodone", pulses, 0);

    run_op(1, MDU_MULT, 1'b0, 32'hFF, 32'hFF);
    check("w8_mulu_lat", cycles, 10);
    check("w8_mulu_hi",  got_hi, 64'hFE);
    check("w8_mulu_lo",  got_lo, 64'h01);
    run_op(1, MDU_DIV, 1'b1, 32'h80, 32'hFF);
    check("w8_divmin_lo", got_lo, 64'h80);
    check("w8_divmin_hi", got_hi, 64'h00);
    run_op(1, MDU_MULT, 1'b1, 32'h80, 32'h80);
    check("w8_muls_hi", got_hi, 64'h40);
    check("w8_muls_lo", got_lo, 64'h00);
    run_op(1, MDU_DIV, 1'b0, 32'hFF, 32'h10);
    check("w8_divu_lo", got_lo, 64'h0F);
    check("w8_divu_hi", got_hi, 64'h0F);
    run_op(1, MDU_DIV, 1'b0, 32'h33, 32'h00);
    check("w8_dz_lat",  cycles,   1);
    check("w8_dz_div0", got_div0, 1'b1);
    check("w8_dz_lo",   got_lo,   64'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
